// File: rtl/rv_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_mdu_pkg
// Purpose  : Shared encodings and constants for the RV32M divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package rv_mdu_pkg;

   // Operand and result width of the core.
   localparam int XLEN_DEFAULT = 32;

   // Divide opcode encodings. op[0] selects the unsigned form and op[1]
   // selects the remainder output.
   localparam logic [1:0] DIV_OP  = 2'b00;
   localparam logic [1:0] DIVU_OP = 2'b01;
   localparam logic [1:0] REM_OP  = 2'b10;
   localparam logic [1:0] REMU_OP = 2'b11;

   // Divider sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } div_state_e;

endpackage : rv_mdu_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division iteration. Shifts
//            {rem, quo} left by one, trial-subtracts the divisor and keeps
//            the difference when it is non-negative.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN:0]   rem_out,
   output logic [XLEN-1:0] quo_out
);

   // One extra guard bit above the partial remainder so the sign of the
   // trial difference is always visible in the top bit.
   logic [XLEN+1:0] shifted;
   logic [XLEN+1:0] diff;

   // Shift, trial-subtract, and restore when the difference goes negative.
   always_comb begin
      shifted = {rem_in, quo_in[XLEN-1]};
      diff    = shifted - {2'b00, divisor};
      if (diff[XLEN+1] == 1'b0) begin
         rem_out = diff[XLEN:0];
         quo_out = {quo_in[XLEN-2:0], 1'b1};
      end else begin
         rem_out = shifted[XLEN:0];
         quo_out = {quo_in[XLEN-2:0], 1'b0};
      end
   end

endmodule : div_step
`default_nettype wire

// File: rtl/rv_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv_div_unit
// Purpose  : Iterative RV32M DIV/DIVU/REM/REMU unit with a start/busy/done
//            handshake. One restoring step per cycle on operand magnitudes,
//            followed by a sign fix-up cycle. Divide-by-zero and signed
//            overflow complete directly in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rv_div_unit
   import rv_mdu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN:0]     rem_q, rem_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   dvs_q, dvs_d;
   logic              is_rem_q, is_rem_d;
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic [XLEN:0]     step_rem;
   logic [XLEN-1:0]   step_quo;

   div_step #(.XLEN(XLEN)) u_div_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (dvs_q),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   // Next-state, datapath and fix-up logic; everything holds by default.
   always_comb begin
      logic            signed_op;
      logic            a_neg;
      logic            b_neg;
      logic [XLEN-1:0] a_mag;
      logic [XLEN-1:0] b_mag;
      logic [XLEN-1:0] quo_fix;
      logic [XLEN-1:0] rem_fix;

      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;

      signed_op = ~op[0];
      a_neg     = signed_op & a[XLEN-1];
      b_neg     = signed_op & b[XLEN-1];
      a_mag     = a_neg ? (~a + 1'b1) : a;
      b_mag     = b_neg ? (~b + 1'b1) : b;

      quo_fix   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
      rem_fix   = neg_rem_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               is_rem_d  = op[1];
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               if (b == '0) begin
                  // Divide by zero: all ones for quotient, dividend for remainder.
                  result_d = op[1] ? a : '1;
                  state_d  = DONE;
               end else if (signed_op && (a == INT_MIN) && (b == '1)) begin
                  // Signed overflow: quotient is the dividend, remainder zero.
                  result_d = op[1] ? '0 : INT_MIN;
                  state_d  = DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = a_mag;
                  dvs_d   = b_mag;
                  cnt_d   = '0;
                  state_d = CALC;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               state_d = FIX;
            end
         end
         FIX: begin
            result_d = is_rem_q ? rem_fix : quo_fix;
            state_d  = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset wins over any pending request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         is_rem_q  <= is_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   assign busy   = (state_q == CALC) || (state_q == FIX);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule : rv_div_unit
`default_nettype wire

// File: tb/tb_rv_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_div_unit
// Purpose  : Directed, table-driven self-checking bench for rv_div_unit,
//            plus hand-written handshake and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_div_unit;

   localparam int LIMIT  = 100;
   localparam int NORM   = 34;
   localparam int NVEC   = 15;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int tests;
   int fails;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs [NVEC];

   rv_div_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge: presents a request for one cycle, then waits for
   // done. lat counts edges from the sampling edge to the done cycle.
   task automatic run(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                      input bit inj, input int inj_cyc,
                      input logic [31:0] inj_a, input logic [31:0] inj_b,
                      output logic [31:0] res, output int lat, output int bcnt,
                      output int ovl);
      op    = t_op;
      a     = t_a;
      b     = t_b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      bcnt  = 0;
      ovl   = 0;
      while (done !== 1'b1 && lat < LIMIT) begin
         if (busy === 1'b1) bcnt++;
         if (inj && lat == inj_cyc) begin
            start = 1'b1;
            a     = inj_a;
            b     = inj_b;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (busy === 1'b1 && done === 1'b1) ovl++;
      res = result;
   endtask

   initial begin
      logic [31:0] res;
      int          lat;
      int          bcnt;
      int          ovl;

      tests = 0;
      fails = 0;

      vecs[0]  = '{"divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,         NORM};
      vecs[1]  = '{"remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          NORM};
      vecs[2]  = '{"div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NORM};
      vecs[3]  = '{"rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NORM};
      vecs[4]  = '{"rem_7_m2",     2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          NORM};
      vecs[5]  = '{"divu_5_0",     2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      vecs[6]  = '{"rem_5_0",      2'b10, 32'd5,          32'd0,          32'd5,          1};
      vecs[7]  = '{"div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      vecs[8]  = '{"rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
      vecs[9]  = '{"div_20_m3",    2'b00, 32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  NORM};
      vecs[10] = '{"rem_m20_3",    2'b10, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE,  NORM};
      vecs[11] = '{"div_min_1",    2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  NORM};
      vecs[12] = '{"divu_max_1",   2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  NORM};
      vecs[13] = '{"remu_max_16",  2'b11, 32'hFFFF_FFFF,  32'd16,         32'd15,         NORM};
      vecs[14] = '{"div_m1_0",     2'b00, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1};

      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      check("reset_busy",   {31'd0, busy},   32'd0);
      check("reset_done",   {31'd0, done},   32'd0);
      check("reset_result", result,          32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven vectors: result, latency, busy length, pulse width, hold.
      for (int i = 0; i < NVEC; i++) begin
         run(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 0, '0, '0, res, lat, bcnt, ovl);
         check({vecs[i].name, "_result"},  res,        vecs[i].exp);
         check({vecs[i].name, "_latency"}, 32'(lat),   32'(vecs[i].lat));
         check({vecs[i].name, "_busy"},    32'(bcnt),  32'(vecs[i].lat == NORM ? 33 : 0));
         check({vecs[i].name, "_overlap"}, 32'(ovl),   32'd0);
         @(negedge clk);
         check({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
         @(negedge clk);
         check({vecs[i].name, "_hold"},    result,     vecs[i].exp);
      end

      // start while busy is ignored; then a back-to-back start in the done cycle.
      run(2'b01, 32'd100, 32'd7, 1'b1, 5, 32'd9, 32'd3, res, lat, bcnt, ovl);
      check("ignore_busy_result",  res,       32'd14);
      check("ignore_busy_latency", 32'(lat),  32'(NORM));
      run(2'b01, 32'd9, 32'd3, 1'b0, 0, '0, '0, res, lat, bcnt, ovl);
      check("b2b_result",  res,       32'd3);
      check("b2b_latency", 32'(lat),  32'(NORM));
      check("b2b_busy",    32'(bcnt), 32'd33);
      @(negedge clk);

      // Reset in the middle of a signed divide.
      op    = 2'b00;
      a     = 32'hFFFF_FFF9;
      b     = 32'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("midrst_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy",   {31'd0, busy}, 32'd0);
      check("midrst_done",   {31'd0, done}, 32'd0);
      check("midrst_result", result,        32'd0);
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) check("midrst_residual_done", {31'd0, done}, 32'd0);
      end
      run(2'b01, 32'd50, 32'd5, 1'b0, 0, '0, '0, res, lat, bcnt, ovl);
      check("after_rst_result",  res,      32'd10);
      check("after_rst_latency", 32'(lat), 32'(NORM));
      @(negedge clk);

      // Reset and start in the same cycle: the request is dropped.
      rst   = 1'b1;
      start = 1'b1;
      op    = 2'b01;
      a     = 32'd9;
      b     = 32'd3;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_busy",   {31'd0, busy}, 32'd0);
      check("rst_start_result", result,        32'd0);
      @(negedge clk);
      check("rst_start_busy2",  {31'd0, busy}, 32'd0);
      check("rst_start_done2",  {31'd0, done}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_rv_div_unit
`default_nettype wire
